// File: rtl/d_mem_responder.sv
// Byte-addressed big-endian data-memory slave with sized writes and wait states.
// Optional alignment checking is enabled by defining D_MEM_ALIGN_CHECK_EN.
module d_mem_responder #(
  parameter int DEPTH_BYTES = 32,
  parameter int WAIT_STATES = 0,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              d_req,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_mem_in,
  input  logic [1:0]        write_data_size,
  input  logic              d_mem_wen,
  output logic [31:0]       d_mem_out,
  output logic              d_ready,
  output logic              d_busy,
  output logic              d_err
);

  localparam int IW = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int XW = ADDR_W + 1;
  localparam logic [XW-1:0] DEPTH_X = XW'(DEPTH_BYTES);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam bit ZERO_WAIT = (WAIT_STATES == 0);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state;
  logic [3:0] cnt;

  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_data;
  logic [1:0]        lat_size;
  logic              lat_wen;

  logic [7:0] mem [DEPTH_BYTES];

  logic [ADDR_W-1:0] a_addr;
  logic [31:0]       a_data;
  logic [1:0]        a_size;
  logic              a_wen;

  logic              accept;
  logic              fire;
  logic              is_wr;
  logic              misalign;
  logic [XW-1:0]     idx [4];
  logic [3:0]        inr;
  logic [3:0]        lane;
  logic [3:0]        we;
  logic [31:0]       wal;
  logic [31:0]       rd_word;

  assign accept = d_req && (state == S_IDLE);

  // Zero-wait accesses use the live port; otherwise the latched request.
  always_comb begin
    a_addr = ZERO_WAIT ? d_addr          : lat_addr;
    a_data = ZERO_WAIT ? d_mem_in        : lat_data;
    a_size = ZERO_WAIT ? write_data_size : lat_size;
    a_wen  = ZERO_WAIT ? d_mem_wen       : lat_wen;
  end

  assign fire = reset_n &&
                (ZERO_WAIT ? accept
                           : (state == S_WAIT && cnt == 4'd1));

  assign is_wr = a_wen && (a_size != 2'd0);

`ifdef D_MEM_ALIGN_CHECK_EN
  always_comb begin
    misalign = 1'b0;
    if (is_wr)
      misalign = (a_size == 2'd2 && a_addr[0]) ||
                 (a_size == 2'd3 && a_addr[1:0] != 2'd0);
    else
      misalign = (a_addr[1:0] != 2'd0);
  end
`else
  assign misalign = 1'b0;
`endif

  // Left-justify write data so lane k always takes wal byte k.
  always_comb begin
    lane = 4'b0000;
    wal  = a_data;
    unique case (a_size)
      2'd1: begin
        lane = 4'b0001;
        wal  = {a_data[7:0], 24'h0};
      end
      2'd2: begin
        lane = 4'b0011;
        wal  = {a_data[15:0], 16'h0};
      end
      2'd3: begin
        lane = 4'b1111;
        wal  = a_data;
      end
      default: begin
        lane = 4'b0000;
        wal  = a_data;
      end
    endcase
  end

  always_comb begin
    rd_word = '0;
    for (int k = 0; k < 4; k++) begin
      idx[k] = {1'b0, a_addr} + XW'(k);
      inr[k] = idx[k] < DEPTH_X;
      we[k]  = fire && is_wr && !misalign &&
               lane[k] && inr[k];
      rd_word[31-8*k -: 8] = inr[k] ?
        mem[idx[k][IW-1:0]] : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (we[k])
        mem[idx[k][IW-1:0]] <= wal[31-8*k -: 8];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      d_mem_out <= 32'h0;
      d_ready   <= 1'b0;
      d_busy    <= 1'b0;
      d_err     <= 1'b0;
      lat_addr  <= '0;
      lat_data  <= 32'h0;
      lat_size  <= 2'd0;
      lat_wen   <= 1'b0;
    end else begin
      d_ready <= 1'b0;
      if (fire) begin
        d_ready   <= 1'b1;
        d_mem_out <= misalign ? 32'h0 : rd_word;
        d_err     <= misalign;
      end
      unique case (state)
        S_IDLE: begin
          if (accept && !ZERO_WAIT) begin
            state    <= S_WAIT;
            cnt      <= WS;
            d_busy   <= 1'b1;
            lat_addr <= d_addr;
            lat_data <= d_mem_in;
            lat_size <= write_data_size;
            lat_wen  <= d_mem_wen;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state  <= S_IDLE;
            cnt    <= 4'd0;
            d_busy <= 1'b0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          d_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d_mem_responder.sv
// Scoreboard bench for d_mem_responder: zero-wait and two-wait instances.
// Honours D_MEM_ALIGN_CHECK_EN in its reference model.
module tb_d_mem_responder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 1'b0;
  logic        req2 = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] din = 32'h0;
  logic [1:0]  sz = 2'd0;
  logic        wen = 1'b0;

  logic [31:0] out0, out2;
  logic        rdy0, rdy2, busy0, busy2, err0, err2;

  int vecs = 0;
  int miss = 0;
  int rc0 = 0;

  logic [7:0]  mdl [32];
  logic [33:0] q0 [$];
  logic [33:0] q2 [$];
  logic [33:0] e0, e2;

  always #5 clk = ~clk;

  d_mem_responder #(.DEPTH_BYTES(32), .WAIT_STATES(0), .ADDR_W(32)) u0 (
    .clk(clk), .reset_n(reset_n), .d_req(req0), .d_addr(addr),
    .d_mem_in(din), .write_data_size(sz), .d_mem_wen(wen),
    .d_mem_out(out0), .d_ready(rdy0), .d_busy(busy0), .d_err(err0)
  );

  d_mem_responder #(.DEPTH_BYTES(32), .WAIT_STATES(2), .ADDR_W(32)) u2 (
    .clk(clk), .reset_n(reset_n), .d_req(req2), .d_addr(addr),
    .d_mem_in(din), .write_data_size(sz), .d_mem_wen(wen),
    .d_mem_out(out2), .d_ready(rdy2), .d_busy(busy2), .d_err(err2)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      miss++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic put(input longint i, input logic [7:0] b);
    if (i < 32) mdl[i] = b;
  endtask

  // Reference: read old big-endian word, then apply sized write.
  task automatic model(input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic w,
                       output logic [31:0] rd, output logic er);
    longint base;
    logic   isw;
    logic   mis;
    base = longint'(a);
    isw  = w && (s != 2'd0);
    mis  = 1'b0;
`ifdef D_MEM_ALIGN_CHECK_EN
    if (isw) mis = (s == 2'd2 && a[0]) || (s == 2'd3 && a[1:0] != 2'd0);
    else     mis = (a[1:0] != 2'd0);
`endif
    rd = 32'h0;
    for (int k = 0; k < 4; k++)
      if (base + k < 32) rd[31-8*k -: 8] = mdl[base + k];
    if (mis) rd = 32'h0;
    er = mis;
    if (isw && !mis) begin
      case (s)
        2'd1: put(base, d[7:0]);
        2'd2: begin
          put(base, d[15:8]);
          put(base + 1, d[7:0]);
        end
        default: begin
          put(base, d[31:24]);
          put(base + 1, d[23:16]);
          put(base + 2, d[15:8]);
          put(base + 3, d[7:0]);
        end
      endcase
    end
  endtask

  task automatic acc0(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic w,
                      input logic c);
    logic [31:0] r;
    logic        e;
    @(negedge clk);
    #1;
    req0 = 1'b1;
    addr = a;
    din  = d;
    sz   = s;
    wen  = w;
    model(a, d, s, w, r, e);
    q0.push_back({c, r, e});
  endtask

  task automatic idle0();
    @(negedge clk);
    #1;
    req0 = 1'b0;
  endtask

  task automatic acc2(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic w,
                      input logic c, input logic [31:0] exp);
    @(negedge clk);
    #1;
    req2 = 1'b1;
    addr = a;
    din  = d;
    sz   = s;
    wen  = w;
    q2.push_back({c, exp, 1'b0});
    @(negedge clk);
    #1;
    req2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rdy0) begin
      rc0++;
      chk("spur0", 64'(q0.size() == 0), 64'd0);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        if (e0[33]) chk("rd0", 64'({out0, err0}), 64'(e0[32:0]));
      end
    end
    if (rdy2) begin
      chk("spur2", 64'(q2.size() == 0), 64'd0);
      if (q2.size() > 0) begin
        e2 = q2.pop_front();
        if (e2[33]) chk("rd2", 64'({out2, err2}), 64'(e2[32:0]));
      end
    end
  end

  initial begin
    int c0;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h00;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_out0", 64'(out0), 64'h0);
    chk("rst_rdy0", 64'(rdy0), 64'h0);
    chk("rst_busy0", 64'(busy0), 64'h0);
    chk("rst_err0", 64'(err0), 64'h0);
    chk("rst_out2", 64'(out2), 64'h0);
    chk("rst_rdy2", 64'(rdy2), 64'h0);
    chk("rst_busy2", 64'(busy2), 64'h0);
    chk("rst_err2", 64'(err2), 64'h0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      acc0(32'(4 * i), {8'(4 * i), 8'(4 * i + 1), 8'(4 * i + 2),
                        8'(4 * i + 3)}, 2'd3, 1'b1, 1'b0);

    acc0(32'd4, 32'hDEADBEEF, 2'd3, 1'b1, 1'b1);
    acc0(32'd4, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'd5, 32'h0, 2'd0, 1'b0, 1'b1);

    acc0(32'd8, 32'h11223344, 2'd3, 1'b1, 1'b1);
    acc0(32'd9, 32'h000000AB, 2'd1, 1'b1, 1'b1);
    acc0(32'd10, 32'h0000CAFE, 2'd2, 1'b1, 1'b1);
    acc0(32'd8, 32'h0, 2'd0, 1'b0, 1'b1);

    acc0(32'd30, 32'h01020304, 2'd3, 1'b1, 1'b1);
    acc0(32'd30, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'hFFFFFFFE, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'hFFFFFFFC, 32'h12345678, 2'd3, 1'b1, 1'b1);
    acc0(32'd12, 32'h0, 2'd0, 1'b1, 1'b1);
    acc0(32'd16, 32'h77777777, 2'd3, 1'b1, 1'b1);
    acc0(32'd16, 32'h0, 2'd3, 1'b0, 1'b1);
    idle0();

    c0 = rc0;
    acc0(32'd16, 32'hA1A2A3A4, 2'd3, 1'b1, 1'b1);
    acc0(32'd20, 32'h0000B1B2, 2'd2, 1'b1, 1'b1);
    acc0(32'd23, 32'h000000C3, 2'd1, 1'b1, 1'b1);
    acc0(32'd24, 32'hD1D2D3D4, 2'd3, 1'b1, 1'b1);
    acc0(32'd16, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'd20, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'd24, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'd28, 32'h0, 2'd0, 1'b0, 1'b1);
    idle0();
    chk("b2b_pulses", 64'(rc0 - c0), 64'd8);
    chk("b2b_busy0", 64'(busy0), 64'h0);

    acc0(32'd6, 32'hA5A5A5A5, 2'd3, 1'b1, 1'b1);
    acc0(32'd4, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'd8, 32'h0, 2'd0, 1'b0, 1'b1);
    acc0(32'd7, 32'h0000005A, 2'd1, 1'b1, 1'b1);
    acc0(32'd5, 32'h00001234, 2'd2, 1'b1, 1'b1);
    acc0(32'd4, 32'h0, 2'd0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++)
      acc0(32'($urandom_range(0, 35)), $urandom,
           2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
    idle0();
    @(negedge clk);

    acc2(32'd0, 32'h0A0B0C0D, 2'd3, 1'b1, 1'b0, 32'h0);
    acc2(32'd4, 32'h01020304, 2'd3, 1'b1, 1'b0, 32'h0);

    @(negedge clk);
    #1;
    req2 = 1'b1;
    addr = 32'd0;
    din  = 32'hCAFEBABE;
    sz   = 2'd3;
    wen  = 1'b1;
    q2.push_back({1'b1, 32'h0A0B0C0D, 1'b0});
    @(negedge clk);
    chk("ws_busy1", 64'(busy2), 64'h1);
    chk("ws_rdy1", 64'(rdy2), 64'h0);
    #1;
    din = 32'h11111111;
    @(negedge clk);
    chk("ws_busy2", 64'(busy2), 64'h1);
    chk("ws_rdy2", 64'(rdy2), 64'h0);
    #1;
    req2 = 1'b0;
    @(negedge clk);
    chk("ws_rdy3", 64'(rdy2), 64'h1);
    chk("ws_busy3", 64'(busy2), 64'h0);
    @(negedge clk);
    chk("ws_rdy4", 64'(rdy2), 64'h0);
    repeat (3) @(negedge clk);
    acc2(32'd0, 32'h0, 2'd0, 1'b0, 1'b1, 32'hCAFEBABE);

    @(negedge clk);
    #1;
    req2 = 1'b1;
    addr = 32'd4;
    din  = 32'h55667788;
    sz   = 2'd3;
    wen  = 1'b1;
    @(negedge clk);
    chk("rw_busy", 64'(busy2), 64'h1);
    #1;
    req2 = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("rw_out", 64'(out2), 64'h0);
    chk("rw_rdy", 64'(rdy2), 64'h0);
    chk("rw_busy0", 64'(busy2), 64'h0);
    chk("rw_err", 64'(err2), 64'h0);
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    acc2(32'd4, 32'h0, 2'd0, 1'b0, 1'b1, 32'h01020304);

    repeat (3) @(negedge clk);
    chk("q0_drain", 64'(q0.size()), 64'd0);
    chk("q2_drain", 64'(q2.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
